// File: rtl/memgen_sp_ram_if.sv
// memgen_sp_ram_if -- access bus of the single-port RAM.
//   master : drives chip_en, wr_en, rd_en, addr, wr_data, wr_be, clear_req
//            and receives rd_data, rd_valid, addr_err, busy.
//   slave  : the RAM side (mirror of master).
// DATA_W and ADDR_W must match the parameters of the RAM bound to it.
interface memgen_sp_ram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic                  chip_en;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  clear_req;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  addr_err;
  logic                  busy;

  modport master (
    output chip_en, wr_en, rd_en, addr, wr_data, wr_be, clear_req,
    input  rd_data, rd_valid, addr_err, busy
  );

  modport slave (
    input  chip_en, wr_en, rd_en, addr, wr_data, wr_be, clear_req,
    output rd_data, rd_valid, addr_err, busy
  );
endinterface

// File: rtl/memgen_sp_ram.sv
// memgen_sp_ram -- single-port RAM with byte-masked writes, read-before-write
// behaviour, configurable read latency (1 or 2) and a zero-fill engine.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high; resets control state, never the array
//   bus   : memgen_sp_ram_if.slave (access requests, read data, status)
// Out-of-range reads return zero with addr_err aligned to rd_valid; out-of-range
// writes are dropped and flag addr_err on the following cycle. While a clear is
// running (busy=1) every request is ignored.
module memgen_sp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 1
) (
  input  logic           clock,
  input  logic           reset,
  memgen_sp_ram_if.slave bus
);

  localparam int                BE_W     = DATA_W / 8;
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                idle_s;
  logic                in_range_s;
  logic                rd_acc_s;
  logic                wr_acc_s;
  logic                wr_oob_s;
  logic                rd_err_tap_s;
  logic [IDX_W-1:0]    idx_s;

  logic [DATA_W-1:0]   rd_data_s1_q;
  logic                rd_valid_s1_q;
  logic                addr_err_q;

  // Extra top bit so DEPTH == 2**ADDR_W still compares correctly.
  assign idle_s     = (state_q == IDLE);
  assign in_range_s = ({1'b0, bus.addr} < DEPTH_L);
  assign idx_s      = bus.addr[IDX_W-1:0];
  assign rd_acc_s   = bus.chip_en & bus.rd_en & idle_s;
  assign wr_acc_s   = bus.chip_en & bus.wr_en & idle_s & in_range_s;
  assign wr_oob_s   = bus.chip_en & bus.wr_en & idle_s & ~in_range_s;

  // State and clear-counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: enter CLEAR on request, walk every word once, then return
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.clear_req) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = CLEAR;
          cnt_d   = cnt_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Array update: zero-fill while clearing, byte-masked writes otherwise.
  // Gated by reset so an aborted clear leaves the current word untouched.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (wr_acc_s) begin
        for (int b = 0; b < BE_W; b++) begin
          if (bus.wr_be[b]) begin
            mem_q[idx_s][8*b +: 8] <= bus.wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  // First read stage; samples the array before this edge's write lands
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid_s1_q <= 1'b0;
      rd_data_s1_q  <= '0;
    end else begin
      rd_valid_s1_q <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_s1_q <= in_range_s ? mem_q[idx_s] : '0;
      end
    end
  end

  // Error flag: write errors one cycle after the request, read errors with rd_valid
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_err_q <= 1'b0;
    end else begin
      addr_err_q <= rd_err_tap_s | wr_oob_s;
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              rd_err_s1_q;
      logic              rd_valid_s2_q;
      logic [DATA_W-1:0] rd_data_s2_q;

      // Second read stage; data only moves when stage one is valid so it holds
      always_ff @(posedge clock) begin
        if (reset) begin
          rd_err_s1_q   <= 1'b0;
          rd_valid_s2_q <= 1'b0;
          rd_data_s2_q  <= '0;
        end else begin
          rd_err_s1_q   <= rd_acc_s & ~in_range_s;
          rd_valid_s2_q <= rd_valid_s1_q;
          if (rd_valid_s1_q) begin
            rd_data_s2_q <= rd_data_s1_q;
          end
        end
      end

      assign rd_err_tap_s = rd_err_s1_q;
      assign bus.rd_data  = rd_data_s2_q;
      assign bus.rd_valid = rd_valid_s2_q;
    end else begin : g_lat1
      assign rd_err_tap_s = rd_acc_s & ~in_range_s;
      assign bus.rd_data  = rd_data_s1_q;
      assign bus.rd_valid = rd_valid_s1_q;
    end
  endgenerate

  assign bus.addr_err = addr_err_q;
  assign bus.busy     = (state_q == CLEAR);

endmodule

// File: tb/tb_memgen_sp_ram.sv
// Bench for memgen_sp_ram: two instances share one clock.
//   dut_a : DEPTH=1000, ADDR_W=10, RD_LAT=1
//   dut_b : DEPTH=16,   ADDR_W=5,  RD_LAT=2
// A behavioural model (array + per-edge expectation slots) tracks both and is
// compared every cycle; directed table vectors and hand sequences add fixed
// expectations for the documented scenarios.
module tb_memgen_sp_ram;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  memgen_sp_ram_if #(.DATA_W(16), .ADDR_W(10)) ia ();
  memgen_sp_ram_if #(.DATA_W(16), .ADDR_W(5))  ib ();

  memgen_sp_ram #(.DATA_W(16), .ADDR_W(10), .DEPTH(1000), .RD_LAT(1)) dut_a (
    .clock(clk), .reset(rst_a), .bus(ia));
  memgen_sp_ram #(.DATA_W(16), .ADDR_W(5), .DEPTH(16), .RD_LAT(2)) dut_b (
    .clock(clk), .reset(rst_b), .bus(ib));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        rst, ce, we, re, cr;
    logic [9:0]  a;
    logic [15:0] wd;
    logic [1:0]  be;
  } snap_t;

  snap_t       sn [2];
  logic [15:0] mm [2][1024];
  bit          sv [2][4];
  bit          se [2][4];
  logic [15:0] sd [2][4];
  bit          m_busy [2];
  int          m_ptr  [2];
  logic [15:0] m_last [2];
  int          dep [2] = '{1000, 16};
  int          lat [2] = '{1, 2};
  int          ecnt = 0;

  // inputs as seen at each rising edge
  always @(posedge clk) begin
    sn[0] <= '{rst_a, ia.chip_en, ia.wr_en, ia.rd_en, ia.clear_req, ia.addr, ia.wr_data, ia.wr_be};
    sn[1] <= '{rst_b, ib.chip_en, ib.wr_en, ib.rd_en, ib.clear_req, 10'(ib.addr), ib.wr_data, ib.wr_be};
  end

  // Slot e%4 holds what outputs must show after edge e.
  task automatic model_edge(input int id, input int e, input snap_t s);
    int s0, s1, sr;
    s0 = e % 4;
    s1 = (e + 1) % 4;
    sv[id][s1] = 1'b0;
    se[id][s1] = 1'b0;
    if (s.rst) begin
      sv[id][s0] = 1'b0; se[id][s0] = 1'b0;
      m_busy[id] = 1'b0; m_ptr[id] = 0; m_last[id] = 16'h0000;
    end else if (m_busy[id]) begin
      mm[id][m_ptr[id]] = 16'h0000;
      m_ptr[id]++;
      if (m_ptr[id] == dep[id]) m_busy[id] = 1'b0;
    end else begin
      sr = (lat[id] == 1) ? s0 : s1;
      if (s.ce && s.re) begin
        sv[id][sr] = 1'b1;
        if (int'(s.a) < dep[id]) sd[id][sr] = mm[id][s.a];
        else begin sd[id][sr] = 16'h0000; se[id][sr] = 1'b1; end
      end
      if (s.ce && s.we) begin
        if (int'(s.a) < dep[id]) begin
          for (int b = 0; b < 2; b++)
            if (s.be[b]) mm[id][s.a][8*b +: 8] = s.wd[8*b +: 8];
        end else se[id][s0] = 1'b1;
      end
      if (s.cr) begin m_busy[id] = 1'b1; m_ptr[id] = 0; end
    end
    if (sv[id][s0]) m_last[id] = sd[id][s0];
  endtask

  // advance the model and compare all outputs, away from the active edge
  always @(negedge clk) begin
    ecnt++;
    for (int id = 0; id < 2; id++) begin
      model_edge(id, ecnt, sn[id]);
      if (chk_en) begin
        chk(id == 0 ? "a_rd_valid" : "b_rd_valid", id == 0 ? ia.rd_valid : ib.rd_valid, sv[id][ecnt % 4]);
        chk(id == 0 ? "a_addr_err" : "b_addr_err", id == 0 ? ia.addr_err : ib.addr_err, se[id][ecnt % 4]);
        chk(id == 0 ? "a_rd_data"  : "b_rd_data",  id == 0 ? ia.rd_data  : ib.rd_data,  m_last[id]);
        chk(id == 0 ? "a_busy"     : "b_busy",     id == 0 ? ia.busy     : ib.busy,     m_busy[id]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  typedef struct {
    bit          ce, we, re;
    int          addr;
    logic [15:0] wd;
    logic [1:0]  be;
    bit          ev, ee;
    logic [15:0] ed;
  } vec_t;

  function automatic vec_t mk(input bit ce, we, re, input int addr, input logic [15:0] wd,
                              input logic [1:0] be, input bit ev, ee, input logic [15:0] ed);
    vec_t v;
    v.ce = ce; v.we = we; v.re = re; v.addr = addr; v.wd = wd; v.be = be;
    v.ev = ev; v.ee = ee; v.ed = ed;
    return v;
  endfunction

  function automatic logic [15:0] fv(input int i);
    return 16'(32'h1001 + i * 32'h0357);
  endfunction

  task automatic idle_a();
    ia.chip_en = 1'b0; ia.wr_en = 1'b0; ia.rd_en = 1'b0; ia.clear_req = 1'b0;
    ia.addr = 10'd0; ia.wr_data = 16'h0000; ia.wr_be = 2'b00;
  endtask

  task automatic idle_b();
    ib.chip_en = 1'b0; ib.wr_en = 1'b0; ib.rd_en = 1'b0; ib.clear_req = 1'b0;
    ib.addr = 5'd0; ib.wr_data = 16'h0000; ib.wr_be = 2'b00;
  endtask

  task automatic b_write(input int a, input logic [15:0] d);
    ib.chip_en = 1'b1; ib.wr_en = 1'b1; ib.rd_en = 1'b0;
    ib.addr = 5'(a); ib.wr_data = d; ib.wr_be = 2'b11;
    @(negedge clk);
    idle_b();
  endtask

  // two-cycle read: nothing after one edge, data after the second
  task automatic b_read(input int a, input logic [15:0] exp, input string nm);
    ib.chip_en = 1'b1; ib.rd_en = 1'b1; ib.wr_en = 1'b0; ib.addr = 5'(a);
    @(negedge clk);
    idle_b();
    chk({nm, "_early"}, ib.rd_valid, 32'd0);
    @(negedge clk);
    chk({nm, "_valid"}, ib.rd_valid, 32'd1);
    chk({nm, "_data"},  ib.rd_data, exp);
  endtask

  vec_t tv [19];

  initial begin
    int   n;
    int   nb;
    bit   rv_seen;
    bit   obs [6];
    logic [15:0] dv [6];
    logic [5:0]  obs_v;

    tv[0]  = mk(1, 1, 0, 5,    16'hA5C3, 2'b11, 0, 0, 16'h0000);
    tv[1]  = mk(1, 0, 1, 5,    16'h0000, 2'b00, 1, 0, 16'hA5C3);
    tv[2]  = mk(1, 1, 0, 7,    16'hFFFF, 2'b11, 0, 0, 16'h0000);
    tv[3]  = mk(1, 1, 0, 7,    16'h1234, 2'b01, 0, 0, 16'h0000);
    tv[4]  = mk(1, 0, 1, 7,    16'h0000, 2'b00, 1, 0, 16'hFF34);
    tv[5]  = mk(1, 1, 0, 7,    16'hAB99, 2'b10, 0, 0, 16'h0000);
    tv[6]  = mk(1, 0, 1, 7,    16'h0000, 2'b00, 1, 0, 16'hAB34);
    tv[7]  = mk(1, 1, 0, 3,    16'hBEEF, 2'b11, 0, 0, 16'h0000);
    tv[8]  = mk(1, 1, 1, 3,    16'h0001, 2'b11, 1, 0, 16'hBEEF);
    tv[9]  = mk(1, 0, 1, 3,    16'h0000, 2'b00, 1, 0, 16'h0001);
    tv[10] = mk(1, 0, 1, 1010, 16'h0000, 2'b00, 1, 1, 16'h0000);
    tv[11] = mk(1, 1, 0, 1010, 16'h5555, 2'b11, 0, 1, 16'h0000);
    tv[12] = mk(1, 0, 1, 999,  16'h0000, 2'b00, 1, 0, 16'h0000);
    tv[13] = mk(1, 1, 0, 999,  16'h7777, 2'b11, 0, 0, 16'h0000);
    tv[14] = mk(1, 0, 1, 999,  16'h0000, 2'b00, 1, 0, 16'h7777);
    tv[15] = mk(0, 1, 0, 5,    16'h0000, 2'b11, 0, 0, 16'h0000);
    tv[16] = mk(1, 0, 1, 5,    16'h0000, 2'b00, 1, 0, 16'hA5C3);
    tv[17] = mk(1, 1, 0, 1000, 16'h1111, 2'b11, 0, 1, 16'h0000);
    tv[18] = mk(1, 0, 1, 1000, 16'h0000, 2'b00, 1, 1, 16'h0000);

    idle_a(); idle_b();
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("a_reset_valid", ia.rd_valid, 32'd0);
    chk("a_reset_data",  ia.rd_data,  32'd0);
    chk("b_reset_busy",  ib.busy,     32'd0);
    chk("b_reset_err",   ib.addr_err, 32'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    chk_en = 1'b1;

    // zero-fill both arrays so every word has a known value
    ia.clear_req = 1'b1; ib.clear_req = 1'b1;
    @(negedge clk);
    ia.clear_req = 1'b0; ib.clear_req = 1'b0;
    n = 0;
    while (ia.busy && n < 1100) begin @(negedge clk); n++; end
    chk("a_clear_len", n, 32'd1000);

    // table vectors on dut_a (latency 1: results visible after one edge)
    for (int i = 0; i < 19; i++) begin
      ia.chip_en = tv[i].ce; ia.wr_en = tv[i].we; ia.rd_en = tv[i].re;
      ia.addr = 10'(tv[i].addr); ia.wr_data = tv[i].wd; ia.wr_be = tv[i].be;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), ia.rd_valid, tv[i].ev);
      chk($sformatf("vec%0d_err", i),   ia.addr_err, tv[i].ee);
      if (tv[i].ev) chk($sformatf("vec%0d_data", i), ia.rd_data, tv[i].ed);
    end
    idle_a();

    // dut_b: fill, then four back-to-back reads with latency 2
    for (int i = 0; i < 16; i++) b_write(i, fv(i));
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        ib.chip_en = 1'b1; ib.rd_en = 1'b1; ib.addr = 5'(j);
      end else idle_b();
      @(negedge clk);
      obs[j] = ib.rd_valid;
      dv[j]  = ib.rd_data;
    end
    idle_b();
    for (int j = 0; j < 6; j++) obs_v[j] = obs[j];
    chk("b_pipe_valid_pattern", obs_v, 32'b011110);
    for (int j = 1; j < 5; j++) chk($sformatf("b_pipe_data%0d", j - 1), dv[j], fv(j - 1));

    // dut_b: full clear, reads while busy must be ignored
    ib.clear_req = 1'b1;
    @(negedge clk);
    ib.clear_req = 1'b0;
    nb = 0; rv_seen = 1'b0;
    while (ib.busy && nb < 40) begin
      ib.chip_en = 1'b1; ib.rd_en = 1'b1; ib.addr = 5'(nb % 16);
      @(negedge clk);
      nb++;
      if (ib.rd_valid) rv_seen = 1'b1;
    end
    idle_b();
    @(negedge clk);
    if (ib.rd_valid) rv_seen = 1'b1;
    chk("b_clear_busy_len", nb, 32'd16);
    chk("b_clear_no_valid", rv_seen, 32'd0);
    for (int i = 0; i < 16; i++) b_read(i, 16'h0000, $sformatf("b_cleared%0d", i));

    // dut_b: reset during clear cycle 4 aborts the clear
    for (int i = 0; i < 16; i++) b_write(i, fv(i));
    ib.clear_req = 1'b1;
    @(negedge clk);
    ib.clear_req = 1'b0;
    chk("b_abort_busy_up", ib.busy, 32'd1);
    repeat (4) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    chk("b_abort_busy_down", ib.busy, 32'd0);
    for (int i = 0; i < 4; i++) b_read(i, 16'h0000, $sformatf("b_abort_w%0d", i));
    b_read(4, fv(4), "b_abort_w4");
    b_read(5, fv(5), "b_abort_w5");

    // randomized traffic on both instances, checked by the model
    for (int c = 0; c < 800; c++) begin
      rst_a = ($urandom_range(0, 199) == 0);
      rst_b = ($urandom_range(0, 99) == 0);
      ia.chip_en = ($urandom_range(0, 3) != 0);
      ia.wr_en = 1'($urandom_range(0, 1)); ia.rd_en = 1'($urandom_range(0, 1));
      ia.wr_be = 2'($urandom_range(0, 3)); ia.wr_data = 16'($urandom);
      ia.addr = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(995, 1023)) : 10'($urandom_range(0, 15));
      ia.clear_req = 1'b0;
      ib.chip_en = ($urandom_range(0, 3) != 0);
      ib.wr_en = 1'($urandom_range(0, 1)); ib.rd_en = 1'($urandom_range(0, 1));
      ib.wr_be = 2'($urandom_range(0, 3)); ib.wr_data = 16'($urandom);
      ib.addr = 5'($urandom_range(0, 19));
      ib.clear_req = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    idle_a(); idle_b();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
